// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
//
// Definitions shared by the pipe_ex arithmetic pipeline and the blocks that
// consume its F result bus.
//
//   PIPE_N       data width of F
//   PIPE_LAT     clock edges from operand sampling in pipe_ex to F update
//   PIPE_DEPTH   default result FIFO depth in the collector
//   PIPE_SEQW    default sequence-tag width
//   PIPE_STAT_W  width of the optional statistics counters
//   pipe_res_t   FIFO entry at default widths, {seq, data}
//   sat_inc()    saturating increment for the statistics counters
// ---------------------------------------------------------------------------
package pipe_pkg;

    localparam int PIPE_N      = 10;
    localparam int PIPE_LAT    = 3;
    localparam int PIPE_DEPTH  = 4;
    localparam int PIPE_SEQW   = 4;
    localparam int PIPE_STAT_W = 16;

    typedef struct packed {
        logic [PIPE_SEQW-1:0] seq;
        logic [PIPE_N-1:0]    data;
    } pipe_res_t;

    function automatic logic [PIPE_STAT_W-1:0] sat_inc(input logic [PIPE_STAT_W-1:0] v);
        return (v == '1) ? v : v + PIPE_STAT_W'(1);
    endfunction

endpackage

// File: rtl/pipe_res_fifo.sv
// ---------------------------------------------------------------------------
// pipe_res_fifo
//
// Small synchronous FIFO holding tagged results for pipe_result_collector.
// The head entry is a combinational read of the storage array so the
// consumer sees it in the same cycle it becomes valid. Storage is cleared
// by reset so the head reads as zero until the first write.
//
// Parameters
//   W      entry width
//   DEPTH  number of entries, power of two, at least 2
//
// Ports
//   clk    clock, rising edge
//   rst    asynchronous active-high reset
//   push   write din at the tail (ignored if full and not popping)
//   pop    remove the head entry (ignored if empty)
//   din    entry to write
//   dout   head entry
//   count  occupied entries, 0..DEPTH
//   full   count == DEPTH
//   empty  count == 0
// ---------------------------------------------------------------------------
module pipe_res_fifo #(
    parameter  int W     = 14,
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]     mem_reg [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;
    logic             push_fire;
    logic             pop_fire;
    logic [DEPTH-1:0] we;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == CW'(DEPTH));
    assign count = count_reg;

    // A pop frees the slot in the same edge, so a push into a full FIFO is
    // accepted when it coincides with a pop.
    assign pop_fire  = pop && !empty;
    assign push_fire = push && (!full || pop_fire);

    // One-hot write enable per entry.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
        assign we[gi] = push_fire && (wr_ptr_reg == PW'(gi));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (we[i]) begin
                    mem_reg[i] <= din;
                end
            end
        end
    end

    // Pointers are exactly log2(DEPTH) bits and wrap by overflow; occupancy
    // is tracked separately so full and empty never alias.
    always_comb begin
        count_next = count_reg;
        case ({push_fire, pop_fire})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_fire) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop_fire) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            count_reg <= count_next;
        end
    end

    assign dout = mem_reg[rd_ptr_reg];

endmodule

// File: rtl/pipe_result_collector.sv
// ---------------------------------------------------------------------------
// pipe_result_collector
//
// Turns the free-running, untagged F bus of pipe_ex into a flow-controlled
// stream of tagged results. A token line follows each issued operand set
// through the pipeline; when its token reaches the end, the F value on
// f_in is stored with a sequence tag in a small FIFO, which is offered to
// the consumer over a valid/ready handshake.
//
// Parameters
//   N      data width of F / out_data
//   LAT    clock edges from operand sampling in pipe_ex to F update
//   DEPTH  FIFO entries, power of two, at least 2
//   SEQW   sequence-tag width
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   issue      a valid operand set is presented to pipe_ex this cycle
//   f_in       F output of pipe_ex
//   out_valid  FIFO holds at least one result
//   out_ready  consumer accepts the head entry
//   out_data   head result
//   out_seq    sequence tag of the head result
//   count      occupied FIFO entries
//   full       count == DEPTH
//   overflow   sticky: a capture was dropped because the FIFO was full
//
// Optional build macro PIPE_RES_STATS_EN adds:
//   stat_cap   saturating count of accepted captures
//   stat_drop  saturating count of dropped captures
// ---------------------------------------------------------------------------
module pipe_result_collector
    import pipe_pkg::*;
#(
    parameter  int N     = PIPE_N,
    parameter  int LAT   = PIPE_LAT,
    parameter  int DEPTH = PIPE_DEPTH,
    parameter  int SEQW  = PIPE_SEQW,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue,
    input  logic [N-1:0]    f_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    out_data,
    output logic [SEQW-1:0] out_seq,
    output logic [CW-1:0]   count,
    output logic            full,
    output logic            overflow
`ifdef PIPE_RES_STATS_EN
    ,
    output logic [15:0]     stat_cap,
    output logic [15:0]     stat_drop
`endif
);

    // Same layout as pipe_res_t, sized by this instance's parameters.
    typedef struct packed {
        logic [SEQW-1:0] seq;
        logic [N-1:0]    data;
    } res_t;

    logic [LAT-1:0]  vld_reg;
    logic [LAT-1:0]  vld_next;
    logic            cap_reg;
    logic [SEQW-1:0] seq_reg;
    logic            overflow_reg;

    logic            fifo_empty;
    logic            pop_fire;
    logic            cap_accept;
    logic            cap_drop;
    res_t            wr_entry;
    res_t            rd_entry;

    // Token line: bit i is set when an issue was sampled i+1 edges ago.
    if (LAT == 1) begin : g_vld_one
        assign vld_next = issue;
    end else begin : g_vld_shift
        assign vld_next = {vld_reg[LAT-2:0], issue};
    end

    // pipe_ex updates F on the LAT-th edge after sampling the operands, so
    // the value is stable on f_in for the whole cycle after that edge. The
    // tap of the token line is registered once more so cap_reg is high in
    // exactly that cycle and the capture lands on edge k+LAT+1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_reg <= '0;
            cap_reg <= 1'b0;
        end else begin
            vld_reg <= vld_next;
            cap_reg <= vld_reg[LAT-1];
        end
    end

    assign out_valid  = !fifo_empty;
    assign pop_fire   = out_valid && out_ready;

    // A full FIFO still accepts a capture when the head leaves in the same
    // edge; otherwise the capture is lost and flagged.
    assign cap_drop   = cap_reg && full && !pop_fire;
    assign cap_accept = cap_reg && !cap_drop;

    assign wr_entry.seq  = seq_reg;
    assign wr_entry.data = f_in;

    // The tag advances on every capture attempt, so drops appear to the
    // consumer as gaps in the tag sequence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq_reg      <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (cap_reg) begin
                seq_reg <= seq_reg + SEQW'(1);
            end
            if (cap_drop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign overflow = overflow_reg;

    pipe_res_fifo #(
        .W     ($bits(res_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cap_accept),
        .pop   (pop_fire),
        .din   (wr_entry),
        .dout  (rd_entry),
        .count (count),
        .full  (full),
        .empty (fifo_empty)
    );

    assign out_data = rd_entry.data;
    assign out_seq  = rd_entry.seq;

`ifdef PIPE_RES_STATS_EN
    logic [PIPE_STAT_W-1:0] stat_cap_reg;
    logic [PIPE_STAT_W-1:0] stat_drop_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_cap_reg  <= '0;
            stat_drop_reg <= '0;
        end else begin
            if (cap_accept) begin
                stat_cap_reg <= sat_inc(stat_cap_reg);
            end
            if (cap_drop) begin
                stat_drop_reg <= sat_inc(stat_drop_reg);
            end
        end
    end

    assign stat_cap  = stat_cap_reg;
    assign stat_drop = stat_drop_reg;
`endif

endmodule

// File: tb/tb_pipe_result_collector.sv
// ---------------------------------------------------------------------------
// tb_pipe_result_collector
//
// Drives pipe_result_collector behind a behavioural stand-in for pipe_ex and
// checks every cycle against a queue-level model of the collector, plus
// hand-computed expectations for the directed scenarios.
// ---------------------------------------------------------------------------
module tb_pipe_result_collector;
    import pipe_pkg::*;

    localparam int N     = PIPE_N;
    localparam int LAT   = PIPE_LAT;
    localparam int DEPTH = 4;
    localparam int SEQW  = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            issue = 1'b0;
    logic            out_ready = 1'b0;
    logic [N-1:0]    f_in;
    logic            out_valid;
    logic [N-1:0]    out_data;
    logic [SEQW-1:0] out_seq;
    logic [CW-1:0]   count;
    logic            full;
    logic            overflow;
`ifdef PIPE_RES_STATS_EN
    logic [15:0]     stat_cap;
    logic [15:0]     stat_drop;
`endif

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;
    int op_a = 0, op_b = 0, op_c = 0, op_d = 0;

    always #5 clk = ~clk;

    pipe_result_collector #(
        .N(N), .LAT(LAT), .DEPTH(DEPTH), .SEQW(SEQW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .issue     (issue),
        .f_in      (f_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_seq   (out_seq),
        .count     (count),
        .full      (full),
        .overflow  (overflow)
`ifdef PIPE_RES_STATS_EN
        ,
        .stat_cap  (stat_cap),
        .stat_drop (stat_drop)
`endif
    );

    function automatic logic [N-1:0] f_of(input int a, input int b, input int c, input int d);
        int r;
        r = ((a + b) + (c - d)) * d;
        return N'(r);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---- stand-in for pipe_ex: F appears LAT edges after operand sampling
    logic [N-1:0] fpipe [0:LAT];
    always @(posedge clk) begin
        fpipe[0] <= f_of(op_a, op_b, op_c, op_d);
        for (int i = 1; i <= LAT; i++) fpipe[i] <= fpipe[i-1];
    end
    assign f_in = fpipe[LAT];

    // ---- reference model: list of pending results, then a bounded queue
    typedef struct {
        int           due;
        logic [N-1:0] val;
    } pend_t;

    pend_t     pend_q[$];
    pipe_res_t mq[$];
    int        m_seq = 0;
    bit        m_ovf = 1'b0;
    int        m_cap_n = 0;
    int        m_drop_n = 0;
    int        ecnt = 0;

    always @(posedge clk or posedge rst) begin
        bit        popping;
        bit        accept;
        bit        cap_now;
        pipe_res_t e;
        if (rst) begin
            pend_q.delete();
            mq.delete();
            m_seq = 0; m_ovf = 1'b0; m_cap_n = 0; m_drop_n = 0;
        end else begin
            ecnt++;
            popping = (mq.size() > 0) && out_ready;
            cap_now = (pend_q.size() > 0) && (pend_q[0].due == ecnt);
            accept  = 1'b0;
            e       = '0;
            if (cap_now) begin
                e.seq  = SEQW'(m_seq);
                e.data = pend_q[0].val;
                void'(pend_q.pop_front());
                accept = (mq.size() < DEPTH) || popping;
                if (accept) begin
                    if (m_cap_n < 65535) m_cap_n++;
                end else begin
                    m_ovf = 1'b1;
                    if (m_drop_n < 65535) m_drop_n++;
                end
                m_seq = (m_seq + 1) % (1 << SEQW);
            end
            if (popping) void'(mq.pop_front());
            if (accept) mq.push_back(e);
            // issue sampled at this edge: F updates LAT edges later, and is
            // captured on the edge after that
            if (issue) pend_q.push_back('{due: ecnt + LAT + 1, val: f_of(op_a, op_b, op_c, op_d)});
        end
    end

    // ---- per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid", int'(out_valid), int'(mq.size() > 0));
            check("count", int'(count), mq.size());
            check("full", int'(full), int'(mq.size() == DEPTH));
            check("overflow", int'(overflow), int'(m_ovf));
            if (mq.size() > 0) begin
                check("out_data", int'(out_data), int'(mq[0].data));
                check("out_seq", int'(out_seq), int'(mq[0].seq));
            end
`ifdef PIPE_RES_STATS_EN
            check("stat_cap", int'(stat_cap), m_cap_n);
            check("stat_drop", int'(stat_drop), m_drop_n);
`endif
        end
    end

    // ---- output monitor for stream-level checks
    bit col_en = 1'b0;
    int col_s[$], col_d[$], col_c[$];
    int max_cnt = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (col_en) begin
            if (int'(count) > max_cnt) max_cnt = int'(count);
            if (out_valid && out_ready) begin
                col_s.push_back(int'(out_seq));
                col_d.push_back(int'(out_data));
                col_c.push_back(cyc);
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        #1 rst = 1'b1;
        issue = 1'b0;
        out_ready = 1'b0;
        step(2);
        check("rst_valid", int'(out_valid), 0);
        check("rst_count", int'(count), 0);
        check("rst_data", int'(out_data), 0);
        check("rst_seq", int'(out_seq), 0);
        check("rst_ovf", int'(overflow), 0);
        rst = 1'b0;
        step(1);
    endtask

    task automatic send(input int a, input int b, input int c, input int d);
        op_a = a; op_b = b; op_c = c; op_d = d;
        issue = 1'b1;
        step(1);
        issue = 1'b0;
    endtask

    task automatic start_col();
        col_s.delete(); col_d.delete(); col_c.delete();
        max_cnt = 0;
        col_en = 1'b1;
    endtask

    int ta[6] = '{1, 2, 3, 5, 1, 9};
    int tb[6] = '{2, 2, 1, 5, 1, 9};
    int tc[6] = '{3, 2, 4, 5, 1, 9};
    int td[6] = '{1, 2, 1, 5, 1, 9};
    int exp3[4] = '{5, 8, 7, 50};
    bit seen;

    initial begin
        rst = 1'b1;
        step(2);
        chk_en = 1'b1;
        rst = 1'b0;
        step(1);

        // 1: single issue, first result after k+LAT+1 edges
        do_reset();
        send(10, 12, 6, 3);
        step(3);
        check("t1_not_yet", int'(out_valid), 0);
        step(1);
        check("t1_valid", int'(out_valid), 1);
        check("t1_data", int'(out_data), 75);
        check("t1_seq", int'(out_seq), 0);
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        check("t1_popped", int'(out_valid), 0);
        $display("txn t1 single issue done");

        // 2: back-to-back with consumer always ready
        do_reset();
        out_ready = 1'b1;
        start_col();
        send(10, 10, 5, 3);
        send(20, 11, 1, 4);
        send(15, 10, 8, 2);
        step(LAT + 4);
        col_en = 1'b0;
        check("t2_n", col_s.size(), 3);
        if (col_s.size() == 3) begin
            check("t2_d0", col_d[0], 66);
            check("t2_d1", col_d[1], 112);
            check("t2_d2", col_d[2], 62);
            check("t2_s0", col_s[0], 0);
            check("t2_s1", col_s[1], 1);
            check("t2_s2", col_s[2], 2);
            check("t2_consec1", col_c[1] - col_c[0], 1);
            check("t2_consec2", col_c[2] - col_c[1], 1);
        end
        check("t2_maxcount", int'(max_cnt <= 1), 1);
        $display("txn t2 streaming done");

        // 3: consumer stalled, six issues into a four-entry FIFO
        do_reset();
        for (int i = 0; i < 6; i++) send(ta[i], tb[i], tc[i], td[i]);
        step(LAT + 2);
        check("t3_full", int'(full), 1);
        check("t3_count", int'(count), 4);
        check("t3_ovf", int'(overflow), 1);
`ifdef PIPE_RES_STATS_EN
        check("t3_stat_drop", int'(stat_drop), 2);
        check("t3_stat_cap", int'(stat_cap), 4);
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t3_drain_valid", int'(out_valid), 1);
            check("t3_drain_seq", int'(out_seq), i);
            check("t3_drain_data", int'(out_data), exp3[i]);
            step(1);
        end
        out_ready = 1'b0;
        check("t3_empty", int'(out_valid), 0);
        check("t3_ovf_sticky", int'(overflow), 1);
        $display("txn t3 overflow done");

        // 4: capture into a full FIFO while the head is popped
        do_reset();
        for (int i = 0; i < 5; i++) send(ta[i], tb[i], tc[i], td[i]);
        step(3);
        check("t4_full_before", int'(full), 1);
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        check("t4_count", int'(count), 4);
        check("t4_ovf", int'(overflow), 0);
        check("t4_head_seq", int'(out_seq), 1);
        step(1);
        $display("txn t4 full+pop done");

        // 5: reset one cycle after an issue discards it
        do_reset();
        send(10, 12, 6, 3);
        #1 rst = 1'b1;
        step(1);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) seen = 1'b1;
            step(1);
        end
        check("t5_no_result", int'(seen), 0);
        send(10, 10, 5, 3);
        step(4);
        check("t5_valid", int'(out_valid), 1);
        check("t5_seq", int'(out_seq), 0);
        check("t5_data", int'(out_data), 66);
        $display("txn t5 reset mid-flight done");

        // 6: twenty issues, tag wraps 15 -> 0
        do_reset();
        out_ready = 1'b1;
        start_col();
        for (int i = 0; i < 20; i++) send(i * 3, i + 7, 2 * i, (i % 5) + 1);
        step(LAT + 4);
        col_en = 1'b0;
        out_ready = 1'b0;
        check("t6_n", col_s.size(), 20);
        if (col_s.size() == 20) begin
            for (int i = 0; i < 20; i++) check("t6_seq", col_s[i], i % 16);
            check("t6_wrap15", col_s[15], 15);
            check("t6_wrap0", col_s[16], 0);
            check("t6_first", col_d[0], 6);
            check("t6_last", col_d[19], 580);
        end
        $display("txn t6 tag wrap done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
